serial_out_mc: RTL and testbench
================================

// Module: serial_out_mc
// PURPOSE
//  Multi-channel, double-buffered parallel-to-serial output stage for the MSDAP datapath.
//  Takes one N_CH x WORD_W result word per frame from the accumulator stage.
//  Shifts all channels out in lock-step on per-channel serial lines.
//  A 1-deep holding register gives gapless back-to-back frames, with a valid/ready load handshake.
// PARAMETERS
//  WORD_W    40  bits per channel word
//  N_CH      2   channels shifted in parallel (L/R = 2)
//  MSB_FIRST 0   0: bit 0 sent first; 1: bit WORD_W-1 sent first
// PORTS
//  sClk        in   1            serial clock; all state changes on posedge
//  start       in   1            reset, synchronous, active-high
//  load_valid  in   1            data_In holds a valid frame
//  load_ready  out  1            frame accepted on posedge when load_valid & load_ready
//  data_In     in   N_CH*WORD_W  channel c = data_In[c*WORD_W +: WORD_W]
//  out_valid   out  1            data_Out carries a valid bit this cycle
//  data_Out    out  N_CH         serial bit per channel
//  word_Sent   out  1            1-cycle pulse coincident with last bit of a frame
// BEHAVIOUR
//  Reset (start=1 at posedge): shifter, hold reg and bit_cnt are cleared; state=IDLE.
//    Outputs after reset: data_Out=0, out_valid=0, word_Sent=0, load_ready=1.
//    A reset mid-frame discards the frame in progress and the held frame; no word_Sent is issued.
//  FRAME_W = WORD_W (+1 with parity, see CONFIGURATION); bit_cnt width = $clog2(FRAME_W+1).
//  load_ready = ~hold_full (registered-state only, no comb path from load_valid).
//  State machine:
//    IDLE:  on accept, the word loads directly into the shifter at that edge.
//           data_Out = first bit and out_valid=1 from that edge; bit_cnt=1; goto SHIFT.
//    SHIFT: an accept while the shifter is busy writes the word to the hold reg (hold_full=1).
//           Each edge presents the next bit; bit_cnt++.
//           The edge presenting bit FRAME_W-1 also sets word_Sent=1 for that cycle only.
//  Frame boundary (edge after the last bit):
//    hold_full      -> shifter <- hold, hold_full=0, first bit out, stay SHIFT (zero gap).
//    else if accept -> shifter <- data_In directly (bypass), stay SHIFT (zero gap).
//    else           -> IDLE; data_Out=0, out_valid=0.
//  Hold is full only when load_ready=0, so an accept and a hold drain never occur on the same edge.
//  data_In is sampled only on the accept edge; it may change freely afterwards.
//  Inactive outputs: data_Out is forced 0 whenever out_valid=0.
// CONFIGURATION
//  Macro SERIAL_OUT_PARITY_EN:
//    defined:   FRAME_W = WORD_W+1. After the data bits, each channel sends its even-parity bit
//               (^word) as the final bit, and word_Sent aligns with that parity bit.
//    undefined: FRAME_W = WORD_W; no parity logic is synthesised.
// STRUCTURE
//  Package msdap_pkg:
//    typedef enum logic {SO_IDLE, SO_SHIFT} so_state_t;
//    localparam MSDAP_WORD_W = 40;
//    localparam MSDAP_N_CH = 2.
//  One sub-module: serial_out_lane (per-channel shift reg + optional parity),
//    instantiated N_CH times via generate.
//  The FSM, bit_cnt and handshake live in the top module and are shared by all lanes.
// TESTING
//  1. start=1 for 2 cycles mid-frame.
//     -> Next cycle out_valid=0, data_Out=0, load_ready=1; no word_Sent.
//  2. Single word, L=40'h00_0000_0005, R=40'h80_0000_0000, MSB_FIRST=0.
//     -> L stream 1,0,1,0..0; R stream 0..0 then 1 on bit 39.
//     -> word_Sent on the 40th out_valid cycle, then IDLE.
//  3. Three frames with load_valid held high.
//     -> out_valid continuous for 120 cycles; word_Sent at cycles 40, 80, 120.
//     -> load_ready drops while hold is full.
//  4. Second load_valid arrives exactly on the last-bit cycle with hold empty.
//     -> Bypass load; zero-gap stream.
//  5. MSB_FIRST=1, L=40'h80_0000_0001.
//     -> First bit 1, next 38 bits 0, last bit 1.
//  6. With SERIAL_OUT_PARITY_EN, L=40'h7 (odd weight).
//     -> 41 bits per frame, bit 41 = 1; word_Sent on cycle 41.

Source files
------------

// File: rtl/msdap_pkg.sv
// Shared types and default sizes for the MSDAP serial output stage.
package msdap_pkg;
  typedef enum logic {SO_IDLE, SO_SHIFT} so_state_t;
  localparam int MSDAP_WORD_W = 40;
  localparam int MSDAP_N_CH   = 2;
endpackage

// File: rtl/serial_out_mc_if.sv
// Load handshake and serial output bundle of serial_out_mc.
interface serial_out_mc_if
  import msdap_pkg::*;
#(
  parameter int WORD_W = MSDAP_WORD_W,
  parameter int N_CH   = MSDAP_N_CH
);
  logic                     load_valid;
  logic                     load_ready;
  logic [N_CH*WORD_W-1:0]   data_In;
  logic                     out_valid;
  logic [N_CH-1:0]          data_Out;
  logic                     word_Sent;

  modport master (output load_valid, data_In,
                  input  load_ready, out_valid, data_Out, word_Sent);
  modport slave  (input  load_valid, data_In,
                  output load_ready, out_valid, data_Out, word_Sent);
endinterface

// File: rtl/serial_out_mc_lane.sv
// One channel of serial_out_mc: shift register plus the even-parity bit
// appended when SERIAL_OUT_PARITY_EN is defined.
module serial_out_lane #(
  parameter int WORD_W    = 40,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
`ifdef SERIAL_OUT_PARITY_EN
  input  logic              send_par,
`endif
  input  logic              valid,
  output logic              dout
);
  logic [WORD_W-1:0] sr;
  logic              bit_now;

  always_ff @(posedge clk) begin
    if (rst)        sr <= '0;
    else if (load)  sr <= din;
    else if (shift) sr <= MSB_FIRST ? {sr[WORD_W-2:0], 1'b0} : {1'b0, sr[WORD_W-1:1]};
  end

`ifdef SERIAL_OUT_PARITY_EN
  logic par;

  always_ff @(posedge clk) begin
    if (rst)       par <= 1'b0;
    else if (load) par <= ^din;
  end

  assign bit_now = send_par ? par : (MSB_FIRST ? sr[WORD_W-1] : sr[0]);
`else
  assign bit_now = MSB_FIRST ? sr[WORD_W-1] : sr[0];
`endif

  // the line idles low whenever no valid bit is on it
  assign dout = valid & bit_now;
endmodule

// File: rtl/serial_out_mc.sv
// Multi-channel double-buffered parallel-to-serial output stage.
// Optional parity bit per frame: define SERIAL_OUT_PARITY_EN.
//   state    | meaning
//   SO_IDLE  | nothing on the lines, shifter empty, hold empty
//   SO_SHIFT | frame on the lines, bit_cnt = bits presented so far
module serial_out_mc
  import msdap_pkg::*;
#(
  parameter int WORD_W    = MSDAP_WORD_W,
  parameter int N_CH      = MSDAP_N_CH,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic            sClk,
  input logic            start,
  serial_out_mc_if.slave bus
);
`ifdef SERIAL_OUT_PARITY_EN
  localparam int FRAME_W = WORD_W + 1;
`else
  localparam int FRAME_W = WORD_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W + 1);

  so_state_t              state, state_nxt;
  logic [CNT_W-1:0]       bit_cnt, cnt_nxt;
  logic                   hold_full, hold_full_nxt;
  logic [N_CH*WORD_W-1:0] hold;
  logic                   accept, last, hold_we, ld_sh, ld_src_hold, shift;

  assign accept = bus.load_valid & ~hold_full;
  assign last   = (bit_cnt == CNT_W'(FRAME_W));

  always_ff @(posedge sClk) begin
    if (start) begin
      state     <= SO_IDLE;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
      hold      <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= cnt_nxt;
      hold_full <= hold_full_nxt;
      if (hold_we) hold <= bus.data_In;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = bit_cnt;
    hold_full_nxt = hold_full;
    hold_we       = 1'b0;
    ld_sh         = 1'b0;
    ld_src_hold   = 1'b0;
    shift         = 1'b0;
    case (state)
      SO_IDLE: begin
        if (accept) begin
          ld_sh     = 1'b1;
          cnt_nxt   = CNT_W'(1);
          state_nxt = SO_SHIFT;
        end
      end
      SO_SHIFT: begin
        if (last) begin
          // hold is full only while load_ready is low, so drain and accept never collide
          if (hold_full) begin
            ld_sh         = 1'b1;
            ld_src_hold   = 1'b1;
            hold_full_nxt = 1'b0;
            cnt_nxt       = CNT_W'(1);
          end else if (accept) begin
            ld_sh   = 1'b1;
            cnt_nxt = CNT_W'(1);
          end else begin
            state_nxt = SO_IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          shift   = 1'b1;
          cnt_nxt = bit_cnt + CNT_W'(1);
          if (accept) begin
            hold_we       = 1'b1;
            hold_full_nxt = 1'b1;
          end
        end
      end
    endcase
  end

  assign bus.load_ready = ~hold_full;
  assign bus.out_valid  = (state == SO_SHIFT);
  assign bus.word_Sent  = (state == SO_SHIFT) & last;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    serial_out_lane #(.WORD_W(WORD_W), .MSB_FIRST(MSB_FIRST)) u_lane (
      .clk      (sClk),
      .rst      (start),
      .load     (ld_sh),
      .shift    (shift),
      .din      (ld_src_hold ? hold[c*WORD_W +: WORD_W] : bus.data_In[c*WORD_W +: WORD_W]),
`ifdef SERIAL_OUT_PARITY_EN
      .send_par (last),
`endif
      .valid    (bus.out_valid),
      .dout     (bus.data_Out[c])
    );
  end
endmodule

// File: tb/tb_serial_out_mc.sv
// Self-checking bench for serial_out_mc: cycle scoreboard fed on every accept,
// frame table with expected line weights, and directed corner sequences.
module tb_serial_out_mc;
  localparam int WORD_W = 40;
  localparam int N_CH   = 2;
`ifdef SERIAL_OUT_PARITY_EN
  localparam int FRAME_W = WORD_W + 1;
`else
  localparam int FRAME_W = WORD_W;
`endif

  typedef struct {
    logic [N_CH-1:0] bits;
    logic            ws;
  } exp_t;

  typedef struct {
    logic [WORD_W-1:0] l;
    logic [WORD_W-1:0] r;
    int                wl;
    int                wr;
  } vec_t;

  logic sClk = 1'b0;
  logic start = 1'b1;
  always #5 sClk = ~sClk;

  serial_out_mc_if #(.WORD_W(WORD_W), .N_CH(N_CH)) bus ();
  serial_out_mc_if #(.WORD_W(WORD_W), .N_CH(N_CH)) bus2 ();

  serial_out_mc #(.WORD_W(WORD_W), .N_CH(N_CH), .MSB_FIRST(1'b0)) dut (
    .sClk(sClk), .start(start), .bus(bus));
  serial_out_mc #(.WORD_W(WORD_W), .N_CH(N_CH), .MSB_FIRST(1'b1)) dut_msb (
    .sClk(sClk), .start(start), .bus(bus2));

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  bit   chk_en = 1'b0;
  int   ones [N_CH];
  int   vcnt, wscnt, rlow;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic fbit(logic [WORD_W-1:0] w, int j);
    if (j >= WORD_W) return ^w;
    return w[j];
  endfunction

  task automatic push_frame(logic [N_CH*WORD_W-1:0] d);
    exp_t e;
    for (int j = 0; j < FRAME_W; j++) begin
      for (int c = 0; c < N_CH; c++) e.bits[c] = fbit(d[c*WORD_W +: WORD_W], j);
      e.ws = (j == FRAME_W - 1);
      sb.push_back(e);
    end
  endtask

  // scoreboard: pop one expected bit-slot per cycle, push a frame on every accept
  always @(negedge sClk) begin : mon
    exp_t e;
    logic ev, ews, exp_ready;
    logic [N_CH-1:0] eb;
    if (chk_en) begin
      if (sb.size() > 0) begin
        e = sb.pop_front(); ev = 1'b1; eb = e.bits; ews = e.ws;
      end else begin
        ev = 1'b0; eb = '0; ews = 1'b0;
      end
      chk("stream{valid,data,sent}", 64'({bus.out_valid, bus.data_Out, bus.word_Sent}),
          64'({ev, eb, ews}));
      exp_ready = (sb.size() < FRAME_W);
      chk("load_ready", 64'(bus.load_ready), 64'(exp_ready));
      if (bus.out_valid === 1'b1)
        for (int c = 0; c < N_CH; c++) ones[c] += int'(bus.data_Out[c]);
      if (bus.out_valid === 1'b1) vcnt++;
      if (bus.word_Sent === 1'b1) wscnt++;
      if (bus.load_ready === 1'b0) rlow++;
      if (start) sb.delete();
      else if (bus.load_valid && exp_ready) push_frame(bus.data_In);
    end
  end

  task automatic send(logic [WORD_W-1:0] l, logic [WORD_W-1:0] r);
    logic rdy;
    bus.load_valid = 1'b1;
    bus.data_In    = {r, l};
    for (int t = 0; t < 200; t++) begin
      @(negedge sClk);
      rdy = bus.load_ready;
      @(posedge sClk); #1;
      if (rdy === 1'b1) return;
    end
    chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 400; t++) begin
      @(posedge sClk); #2;
      if (sb.size() == 0) begin
        repeat (2) @(posedge sClk);
        #1;
        return;
      end
    end
    chk("idle_timeout", 64'(0), 64'(1));
  endtask

  task automatic clr_counts();
    vcnt = 0; wscnt = 0; rlow = 0;
    for (int c = 0; c < N_CH; c++) ones[c] = 0;
  endtask

  vec_t vt[4];

  initial begin
    vt[0] = '{l: 40'h00_0000_0005, r: 40'h80_0000_0000, wl: 2,  wr: 1};
    vt[1] = '{l: 40'hFF_FFFF_FFFF, r: 40'h00_0000_0000, wl: 40, wr: 0};
    vt[2] = '{l: 40'h12_3456_789A, r: 40'hA5_A5A5_A5A5, wl: 17, wr: 20};
    vt[3] = '{l: 40'h00_0000_0007, r: 40'h00_0000_0000, wl: 3,  wr: 0};

    bus.load_valid  = 1'b0; bus.data_In  = '0;
    bus2.load_valid = 1'b0; bus2.data_In = '0;
    clr_counts();
    repeat (3) @(posedge sClk);
    #1 start = 1'b0;
    chk_en = 1'b1;

    @(negedge sClk);
    chk("reset_ready", 64'(bus.load_ready), 64'(1));
    chk("reset_valid", 64'(bus.out_valid), 64'(0));

    // frame table, one frame at a time, line weights include the parity bit if present
    for (int i = 0; i < 4; i++) begin
      @(posedge sClk); #1;
      clr_counts();
      send(vt[i].l, vt[i].r);
      bus.load_valid = 1'b0;
      wait_idle();
`ifdef SERIAL_OUT_PARITY_EN
      chk("weight_l", 64'(ones[0]), 64'(vt[i].wl + (vt[i].wl % 2)));
      chk("weight_r", 64'(ones[1]), 64'(vt[i].wr + (vt[i].wr % 2)));
`else
      chk("weight_l", 64'(ones[0]), 64'(vt[i].wl));
      chk("weight_r", 64'(ones[1]), 64'(vt[i].wr));
`endif
      chk("sent_count", 64'(wscnt), 64'(1));
    end

    // reset held two cycles mid-frame
    send(40'hAA_AAAA_AAAA, 40'h55_5555_5555);
    bus.load_valid = 1'b0;
    repeat (10) @(posedge sClk);
    #1 start = 1'b1;
    repeat (2) @(posedge sClk);
    #1 start = 1'b0;
    clr_counts();
    @(negedge sClk);
    chk("mid_reset_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_reset_data", 64'(bus.data_Out), 64'(0));
    chk("mid_reset_ready", 64'(bus.load_ready), 64'(1));
    wait_idle();
    chk("mid_reset_no_sent", 64'(wscnt), 64'(0));

    // three frames with load_valid held high
    clr_counts();
    send(40'h01_2345_6789, 40'hFE_DCBA_9876);
    send(40'h0F_0F0F_0F0F, 40'hF0_F0F0_F0F0);
    send(40'h80_0000_0001, 40'h00_0000_0001);
    bus.load_valid = 1'b0;
    wait_idle();
    chk("b2b_valid_cycles", 64'(vcnt), 64'(3 * FRAME_W));
    chk("b2b_sent_count", 64'(wscnt), 64'(3));
    chk("b2b_ready_dropped", 64'(rlow > 0), 64'(1));

    // second frame arrives exactly on the last-bit cycle with hold empty
    send(40'h33_3333_3333, 40'hC0_0000_0003);
    bus.load_valid = 1'b0;
    repeat (FRAME_W - 1) @(posedge sClk);
    #1;
    bus.load_valid = 1'b1;
    bus.data_In    = {40'h00_0000_00FF, 40'h11_0000_0001};
    @(negedge sClk);
    chk("bypass_last_bit", 64'(bus.word_Sent), 64'(1));
    chk("bypass_ready", 64'(bus.load_ready), 64'(1));
    @(posedge sClk); #1;
    bus.load_valid = 1'b0;
    @(negedge sClk);
    chk("bypass_no_gap", 64'(bus.out_valid), 64'(1));
    wait_idle();

    // MSB-first instance
    bus2.load_valid = 1'b1;
    bus2.data_In    = {40'hFF_0000_0000, 40'h80_0000_0001};
    @(posedge sClk); #1;
    bus2.load_valid = 1'b0;
    for (int j = 0; j < FRAME_W; j++) begin
      @(negedge sClk);
      chk("msb{valid,R,L,sent}", 64'({bus2.out_valid, bus2.data_Out, bus2.word_Sent}),
          64'({1'b1, (j < 8), (j == 0 || j == WORD_W - 1), (j == FRAME_W - 1)}));
    end
    @(negedge sClk);
    chk("msb_idle", 64'({bus2.out_valid, bus2.data_Out}), 64'(0));

    repeat (3) @(posedge sClk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
